// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: descriptor-driven layer/group sequencer feeding the systolic core cfg_* bundle.
// Optional WAIT watchdog and ERR state are built when CNN_SEQ_TIMEOUT_EN is defined.
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS     = 4,
  parameter int MAX_GROUPS     = 8,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int LID_W          = $clog2(NUM_LAYERS*MAX_GROUPS),
  parameter int LSEL_W         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  parameter int CNT_W          = $clog2(NUM_LAYERS+1)
) (
  input  logic              clk_i,
  input  logic              rst_sync_n_i,
  input  logic              host_start_i,
  input  logic [CNT_W-1:0]  num_layers_i,
  output logic              host_done_o,
  output logic              busy_o,
  output logic              err_o,
  input  logic              desc_wr_en_i,
  input  logic [LSEL_W-1:0] desc_wr_layer_i,
  input  logic [2:0]        desc_wr_field_i,
  input  logic [31:0]       desc_wr_data_i,
  output logic              req_load_weight_o,
  output logic [LID_W-1:0]  layer_id_o,
  input  logic              weight_loaded_i,
  output logic [31:0]       cfg_img_w_o,
  output logic [31:0]       cfg_img_h_o,
  output logic [3:0]        cfg_kernel_r_o,
  output logic              cfg_do_bias_o,
  output logic              cfg_do_relu_o,
  output logic              cfg_do_pool_o,
  output logic              cfg_do_quant_o,
  output logic [4:0]        cfg_quant_shift_o,
  output logic [ADDR_W-1:0] cfg_read_base_o,
  output logic [ADDR_W-1:0] cfg_write_base_o,
  output logic [15:0]       cfg_num_input_channels_o,
  output logic              core_start_o,
  input  logic              core_done_i
);
  localparam int GRP_W = $clog2(MAX_GROUPS+1);

`ifdef CNN_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RUN, S_WAIT, S_NEXT, S_DONE, S_ERR} state_t;
  logic [WD_W-1:0] wd_q, wd_d;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RUN, S_WAIT, S_NEXT, S_DONE} state_t;
`endif

  state_t             state_q, state_d;
  logic [LSEL_W-1:0]  layer_q, layer_d;
  logic [GRP_W-1:0]   group_q, group_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0]        img_w_q  [NUM_LAYERS];
  logic [31:0]        img_h_q  [NUM_LAYERS];
  logic [3:0]         kr_q     [NUM_LAYERS];
  logic [3:0]         flags_q  [NUM_LAYERS];
  logic [4:0]         shift_q  [NUM_LAYERS];
  logic [7:0]         ngrp_q   [NUM_LAYERS];
  logic [15:0]        inch_q   [NUM_LAYERS];
  logic [ADDR_W-1:0]  rbase_q  [NUM_LAYERS];
  logic [ADDR_W-1:0]  wbase_q  [NUM_LAYERS];
  logic [15:0]        stride_q [NUM_LAYERS];

  logic               desc_we;
  logic [GRP_W-1:0]   ngrp_eff;

  assign desc_we = desc_wr_en_i && (state_q == S_IDLE || state_q == S_DONE);

  // Table is only writable while no run is in flight; out-of-range layer indices match no entry.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (!rst_sync_n_i) begin
        img_w_q[l]  <= '0;
        img_h_q[l]  <= '0;
        kr_q[l]     <= '0;
        flags_q[l]  <= '0;
        shift_q[l]  <= '0;
        ngrp_q[l]   <= '0;
        inch_q[l]   <= '0;
        rbase_q[l]  <= '0;
        wbase_q[l]  <= '0;
        stride_q[l] <= '0;
      end else if (desc_we && desc_wr_layer_i == LSEL_W'(l)) begin
        case (desc_wr_field_i)
          3'd0: img_w_q[l] <= desc_wr_data_i;
          3'd1: img_h_q[l] <= desc_wr_data_i;
          3'd2: begin
            kr_q[l]    <= desc_wr_data_i[3:0];
            flags_q[l] <= desc_wr_data_i[7:4];
            shift_q[l] <= desc_wr_data_i[12:8];
            ngrp_q[l]  <= desc_wr_data_i[23:16];
          end
          3'd3: inch_q[l]   <= desc_wr_data_i[15:0];
          3'd4: rbase_q[l]  <= ADDR_W'(desc_wr_data_i);
          3'd5: wbase_q[l]  <= ADDR_W'(desc_wr_data_i);
          3'd6: stride_q[l] <= desc_wr_data_i[15:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_sync_n_i) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      group_q <= '0;
      count_q <= '0;
`ifdef CNN_SEQ_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      group_q <= group_d;
      count_q <= count_d;
`ifdef CNN_SEQ_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  always_comb begin
    ngrp_eff = GRP_W'(ngrp_q[layer_q]);
    if (ngrp_q[layer_q] == 8'd0)                ngrp_eff = GRP_W'(1);
    else if (int'(ngrp_q[layer_q]) > MAX_GROUPS) ngrp_eff = GRP_W'(MAX_GROUPS);
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    group_d = group_q;
    count_d = count_q;
`ifdef CNN_SEQ_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      S_IDLE: if (host_start_i) begin
        count_d = (int'(num_layers_i) > NUM_LAYERS) ? CNT_W'(NUM_LAYERS) : num_layers_i;
        layer_d = '0;
        group_d = '0;
        state_d = (count_d == '0) ? S_DONE : S_REQ;
      end
      S_REQ:  if (weight_loaded_i) state_d = S_RUN;
      S_RUN: begin
`ifdef CNN_SEQ_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done_i) state_d = S_NEXT;
`ifdef CNN_SEQ_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES-1)) state_d = S_ERR;
        else wd_d = wd_q + WD_W'(1);
`endif
      end
      S_NEXT: begin
        if (group_q < ngrp_eff - GRP_W'(1)) begin
          group_d = group_q + GRP_W'(1);
          state_d = S_REQ;
        end else if (int'(layer_q) < int'(count_q) - 1) begin
          layer_d = layer_q + LSEL_W'(1);
          group_d = '0;
          state_d = S_REQ;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: if (!host_start_i) state_d = S_IDLE;
`ifdef CNN_SEQ_TIMEOUT_EN
      S_ERR:  if (!host_start_i) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  logic cfg_act;
  assign cfg_act = (state_q == S_RUN) || (state_q == S_WAIT);

  assign req_load_weight_o = (state_q == S_REQ);
  assign layer_id_o  = (state_q == S_REQ) ? LID_W'(int'(layer_q)*MAX_GROUPS + int'(group_q)) : '0;
  assign core_start_o = (state_q == S_RUN);
  assign busy_o = (state_q == S_REQ) || (state_q == S_RUN) || (state_q == S_WAIT) || (state_q == S_NEXT);
`ifdef CNN_SEQ_TIMEOUT_EN
  assign err_o       = (state_q == S_ERR);
  assign host_done_o = (state_q == S_DONE) || (state_q == S_ERR);
`else
  assign err_o       = 1'b0;
  assign host_done_o = (state_q == S_DONE);
`endif

  assign cfg_img_w_o              = cfg_act ? img_w_q[layer_q]    : '0;
  assign cfg_img_h_o              = cfg_act ? img_h_q[layer_q]    : '0;
  assign cfg_kernel_r_o           = cfg_act ? kr_q[layer_q]       : '0;
  assign cfg_do_bias_o            = cfg_act & flags_q[layer_q][0];
  assign cfg_do_relu_o            = cfg_act & flags_q[layer_q][1];
  assign cfg_do_pool_o            = cfg_act & flags_q[layer_q][2];
  assign cfg_do_quant_o           = cfg_act & flags_q[layer_q][3];
  assign cfg_quant_shift_o        = cfg_act ? shift_q[layer_q]    : '0;
  assign cfg_read_base_o          = cfg_act ? rbase_q[layer_q]    : '0;
  assign cfg_num_input_channels_o = cfg_act ? inch_q[layer_q]     : '0;
  // Address wraps naturally at ADDR_W bits.
  assign cfg_write_base_o = cfg_act ?
      wbase_q[layer_q] + ADDR_W'(group_q) * ADDR_W'(stride_q[layer_q]) : '0;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed-vector bench for cnn_layer_sequencer with hand-computed expectations.
// Define CNN_SEQ_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_cnn_layer_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_start;
  logic [2:0]  num_layers;
  logic        host_done, busy, err;
  logic        desc_wr_en;
  logic [1:0]  desc_wr_layer;
  logic [2:0]  desc_wr_field;
  logic [31:0] desc_wr_data;
  logic        req_load;
  logic [4:0]  layer_id;
  logic        weight_loaded;
  logic [31:0] img_w, img_h;
  logic [3:0]  kernel_r;
  logic        do_bias, do_relu, do_pool, do_quant;
  logic [4:0]  quant_shift;
  logic [31:0] read_base, write_base;
  logic [15:0] in_ch;
  logic        core_start;
  logic        core_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int passes, first_req, done_lat;
  logic [31:0] id_log [16];
  logic [31:0] wb_log [16];
  logic [31:0] rb_log [16];
  logic [31:0] imgw_log [16];
  logic [31:0] imgh_log [16];
  logic [31:0] ctl_log [16];
  logic [31:0] inch_log [16];

  cnn_layer_sequencer #(.NUM_LAYERS(4), .MAX_GROUPS(8), .ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_sync_n_i(rst_n),
    .host_start_i(host_start), .num_layers_i(num_layers),
    .host_done_o(host_done), .busy_o(busy), .err_o(err),
    .desc_wr_en_i(desc_wr_en), .desc_wr_layer_i(desc_wr_layer),
    .desc_wr_field_i(desc_wr_field), .desc_wr_data_i(desc_wr_data),
    .req_load_weight_o(req_load), .layer_id_o(layer_id), .weight_loaded_i(weight_loaded),
    .cfg_img_w_o(img_w), .cfg_img_h_o(img_h), .cfg_kernel_r_o(kernel_r),
    .cfg_do_bias_o(do_bias), .cfg_do_relu_o(do_relu), .cfg_do_pool_o(do_pool),
    .cfg_do_quant_o(do_quant), .cfg_quant_shift_o(quant_shift),
    .cfg_read_base_o(read_base), .cfg_write_base_o(write_base),
    .cfg_num_input_channels_o(in_ch),
    .core_start_o(core_start), .core_done_i(core_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wdesc(input int l, input int f, input logic [31:0] d);
    desc_wr_en    = 1'b1;
    desc_wr_layer = 2'(l);
    desc_wr_field = 3'(f);
    desc_wr_data  = d;
    step();
    desc_wr_en    = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"}, req_load, 0);
    chk({tag, "_start"}, core_start, 0);
    chk({tag, "_lid"}, layer_id, 0);
    chk({tag, "_imgw"}, img_w, 0);
    chk({tag, "_wb"}, write_base, 0);
    chk({tag, "_done"}, host_done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Acts as weight loader and core; noise adds ignored strobes and a blocked descriptor write.
  task automatic run_seq(input int nl, input bit noise, input int abort_pass);
    int  wait_ctr, start_cyc, ld_cyc, last_done_cyc;
    bit  done, aborted;
    host_start = 1'b1;
    num_layers = 3'(nl);
    start_cyc = cyc; ld_cyc = 0; last_done_cyc = 0;
    passes = 0; first_req = -1; done_lat = -1; wait_ctr = 0;
    done = 1'b0; aborted = 1'b0;
    for (int k = 0; k < 400 && !done && !aborted; k++) begin
      step();
      weight_loaded = 1'b0; core_done = 1'b0; desc_wr_en = 1'b0;
      if (host_done) begin
        done = 1'b1;
        done_lat = cyc - last_done_cyc;
      end else if (req_load) begin
        if (first_req < 0) first_req = cyc - start_cyc;
        if (passes < 16) id_log[passes] = 32'(layer_id);
        if (passes == 0) begin
          chk("cfg_imgw_in_req", img_w, 0);
          chk("cfg_wb_in_req", write_base, 0);
        end
        weight_loaded = 1'b1; core_done = noise; ld_cyc = cyc;
      end else if (core_start) begin
        if (passes == 0) begin
          chk("wl_to_start_lat", cyc - ld_cyc, 1);
          chk("lid_in_run", layer_id, 0);
        end
        if (passes < 16) begin
          wb_log[passes]   = write_base;
          rb_log[passes]   = read_base;
          imgw_log[passes] = img_w;
          imgh_log[passes] = img_h;
          inch_log[passes] = 32'(in_ch);
          ctl_log[passes]  = 32'({quant_shift, do_quant, do_pool, do_relu, do_bias, kernel_r});
        end
        passes++; wait_ctr = 3; core_done = noise;
      end else if (wait_ctr > 0) begin
        if (abort_pass == passes - 1) begin
          rst_n = 1'b0; aborted = 1'b1;
        end else begin
          if (noise && wait_ctr == 3) begin
            desc_wr_en = 1'b1; desc_wr_layer = 2'd0; desc_wr_field = 3'd0; desc_wr_data = 32'hDEAD;
          end
          wait_ctr--;
          if (wait_ctr == 0) begin
            core_done = 1'b1; last_done_cyc = cyc;
          end
        end
      end
    end
    weight_loaded = 1'b0; core_done = 1'b0; desc_wr_en = 1'b0;
    if (!done && !aborted) chk("run_completed", 0, 1);
  endtask

  task automatic finish_run(input string tag);
    chk({tag, "_host_done"}, host_done, 1);
    chk({tag, "_busy_low"}, busy, 0);
    host_start = 1'b0;
    step();
    chk({tag, "_done_clear"}, host_done, 0);
  endtask

  initial begin
    rst_n = 1'b0; host_start = 1'b0; num_layers = '0;
    desc_wr_en = 1'b0; desc_wr_layer = '0; desc_wr_field = '0; desc_wr_data = '0;
    weight_loaded = 1'b0; core_done = 1'b0;
    repeat (3) step();
    chk_quiet("reset");
    rst_n = 1'b1;
    step();

    // LeNet-style two-layer program
    wdesc(0, 0, 32);  wdesc(0, 1, 32); wdesc(0, 2, 32'h0001_08F5); wdesc(0, 3, 1);
    wdesc(0, 4, 0);   wdesc(0, 5, 32'h400); wdesc(0, 6, 0);
    wdesc(1, 0, 14);  wdesc(1, 1, 14); wdesc(1, 2, 32'h0003_0065); wdesc(1, 3, 6);
    wdesc(1, 4, 32'h400); wdesc(1, 5, 32'h800); wdesc(1, 6, 25);

    run_seq(2, 1'b0, -1);
    chk("lenet_passes", passes, 4);
    chk("lenet_start_lat", first_req, 1);
    chk("lenet_done_lat", done_lat, 2);
    chk("lenet_id0", id_log[0], 0);
    chk("lenet_id1", id_log[1], 8);
    chk("lenet_id2", id_log[2], 9);
    chk("lenet_id3", id_log[3], 10);
    chk("lenet_wb0", wb_log[0], 32'h400);
    chk("lenet_wb1", wb_log[1], 32'h800);
    chk("lenet_wb2", wb_log[2], 32'h819);
    chk("lenet_wb3", wb_log[3], 32'h832);
    chk("lenet_rb0", rb_log[0], 0);
    chk("lenet_rb3", rb_log[3], 32'h400);
    chk("lenet_imgw0", imgw_log[0], 32);
    chk("lenet_imgh1", imgh_log[1], 14);
    chk("lenet_ctl0", ctl_log[0], 32'h8F5);
    chk("lenet_ctl2", ctl_log[2], 32'h065);
    chk("lenet_inch0", inch_log[0], 1);
    chk("lenet_inch3", inch_log[3], 6);
    chk("lenet_err", err, 0);
    finish_run("lenet");

    // Zero layers: DONE immediately, no requests
    host_start = 1'b1; num_layers = 3'd0;
    step();
    chk("zero_host_done", host_done, 1);
    chk("zero_req", req_load, 0);
    chk("zero_busy", busy, 0);
    host_start = 1'b0;
    step();
    chk("zero_back_idle", host_done, 0);

    // num_groups 0 -> 1 pass, 200 -> 8 passes; layer0 stride 4
    wdesc(0, 6, 4);
    wdesc(0, 2, 32'h0000_08F5);
    run_seq(1, 1'b0, -1);
    chk("ngrp0_passes", passes, 1);
    finish_run("ngrp0");
    wdesc(0, 2, 32'h00C8_08F5);
    run_seq(1, 1'b0, -1);
    chk("ngrp200_passes", passes, 8);
    chk("ngrp200_id7", id_log[7], 7);
    chk("ngrp200_wb7", wb_log[7], 32'h41C);
    finish_run("ngrp200");

    // num_layers 7 clamps to 4: 1 + 3 + 1 + 1 passes
    wdesc(0, 2, 32'h0001_08F5);
    run_seq(7, 1'b0, -1);
    chk("clamp_passes", passes, 6);
    chk("clamp_id5", id_log[5], 24);
    finish_run("clamp");

    // Stray core_done in REQ/RUN and descriptor writes during WAIT
    run_seq(2, 1'b1, -1);
    chk("noise_passes", passes, 4);
    chk("noise_id3", id_log[3], 10);
    chk("noise_wb1", wb_log[1], 32'h800);
    finish_run("noise");
    run_seq(2, 1'b0, -1);
    chk("table_kept_imgw0", imgw_log[0], 32);
    finish_run("table_kept");

    // Reset in WAIT of layer1 group1
    run_seq(2, 1'b0, 2);
    chk("abort_passes", passes, 3);
    host_start = 1'b0;
    step();
    chk_quiet("abort");
    rst_n = 1'b1;
    step();
    run_seq(1, 1'b0, -1);
    chk("restart_passes", passes, 1);
    chk("restart_id0", id_log[0], 0);
    chk("restart_imgw_cleared", imgw_log[0], 0);
    finish_run("restart");

`ifdef CNN_SEQ_TIMEOUT_EN
    begin
      int t;
      bit seen;
      host_start = 1'b1; num_layers = 3'd1;
      step();
      chk("wd_req", req_load, 1);
      weight_loaded = 1'b1;
      step();
      weight_loaded = 1'b0;
      chk("wd_start", core_start, 1);
      t = 0; seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        step();
        t++;
        if (err) seen = 1'b1;
      end
      chk("wd_cycles", t, 17);
      chk("wd_err", err, 1);
      chk("wd_host_done", host_done, 1);
      chk("wd_busy", busy, 0);
      host_start = 1'b0;
      step();
      chk("wd_err_clear", err, 0);
      chk("wd_done_clear", host_done, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
